// File: rtl/rca_pkg.sv
// Shared types and helpers for the ripple-carry-adder self-test: FSM state encoding,
// golden sum reference and the default sweep length.
package rca_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Widest adder the golden function supports; callers cast the result down to N+1 bits.
    localparam int MAX_N = 32;
    localparam int N_DEF = 4;
    localparam int NVEC  = 2 ** (2 * N_DEF + 1);

    function automatic logic [MAX_N:0] golden_sum(
        input logic [MAX_N-1:0] a,
        input logic [MAX_N-1:0] b,
        input logic             ci
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_N{1'b0}}, ci};
    endfunction

endpackage

// File: rtl/rca_vec_gen.sv
// Exhaustive test-vector counter V = {A,B,Ci}; Ci is the LSB so it toggles fastest.
module rca_vec_gen #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] v,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (clr) begin
            v <= '0;
        end else if (inc) begin
            v <= v + 1'b1;
        end
    end

    assign last = &v;

endmodule

// File: rtl/rca_bist_checker.sv
// Built-in self-test for an N-bit ripple carry adder: sweeps every {A,B,Ci}, compares
// {Co,S} against the golden sum and reports pass, error count and first failing vector.
module rca_bist_checker
    import rca_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     A,
    output logic [N-1:0]     B,
    output logic             Ci,
    input  logic [N-1:0]     S,
    input  logic             Co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2*N+1:0]   vec_count,
    output logic [2*N:0]     first_fail
);

    localparam int VW = 2 * N + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    state_t          state_reg;
    logic [CW-1:0]   wait_reg;
    logic [VW-1:0]   v;
    logic            last;
    logic            clr_v;
    logic            inc_v;
    logic            accept;
    logic [N:0]      expected;
    logic            mismatch;

    assign accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign clr_v    = accept;
    assign inc_v    = (state_reg == ST_CHECK) && !last;
    assign expected = (N + 1)'(golden_sum(MAX_N'(A), MAX_N'(B), Ci));
    assign mismatch = ({Co, S} != expected);

    rca_vec_gen #(
        .W (VW)
    ) u_vec_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_v),
        .inc  (inc_v),
        .v    (v),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            wait_reg   <= '0;
            A          <= '0;
            B          <= '0;
            Ci         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            first_fail <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // A/B/Ci keep the last vector until the next DRIVE overwrites them.
                    if (accept) begin
                        err_count  <= '0;
                        vec_count  <= '0;
                        first_fail <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state_reg  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    {A, B, Ci} <= v;
                    if (SETTLE == 0) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        wait_reg  <= CW'((SETTLE > 0) ? SETTLE - 1 : 0);
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (wait_reg == '0) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        wait_reg <= wait_reg - 1'b1;
                    end
                end
                ST_CHECK: begin
                    vec_count <= vec_count + 1'b1;
                    if (mismatch) begin
                        if (!(&err_count)) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (err_count == '0) begin
                            first_fail <= v;
                        end
                    end
                    if (last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_count == '0) && !mismatch;
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_DRIVE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_bist_checker.sv
// Scoreboard bench for rca_bist_checker with behavioural adders and injectable faults.
module tb_rca_bist_checker;

    typedef struct {
        int dut;
        bit pass;
        int err;
        int vec;
        int ff;
        bit chk_ff;
        int lat;
        int start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic co_stuck0 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: N=4 SETTLE=2 ERR_W=10, optional Co stuck-at-0
    logic [3:0] A0, B0, S0;
    logic       Ci0, Co0, busy0, done0, pass0;
    logic [9:0] err0;
    logic [9:0] vec0;
    logic [8:0] ff0;
    logic [4:0] sum0;
    assign sum0 = {1'b0, A0} + {1'b0, B0} + {4'b0, Ci0};
    assign S0   = sum0[3:0];
    assign Co0  = co_stuck0 ? 1'b0 : sum0[4];

    rca_bist_checker #(.N(4), .SETTLE(2), .ERR_W(10)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(A0), .B(B0), .Ci(Ci0), .S(S0), .Co(Co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
        .first_fail(ff0)
    );

    // DUT 1: ERR_W=4, S[0] stuck-at-0
    logic [3:0] A1, B1, S1;
    logic       Ci1, Co1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [9:0] vec1;
    logic [8:0] ff1;
    logic [4:0] sum1;
    assign sum1 = {1'b0, A1} + {1'b0, B1} + {4'b0, Ci1};
    assign S1   = {sum1[3:1], 1'b0};
    assign Co1  = sum1[4];

    rca_bist_checker #(.N(4), .SETTLE(2), .ERR_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Ci(Ci1), .S(S1), .Co(Co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1),
        .first_fail(ff1)
    );

    // DUT 2: SETTLE=0, correct adder
    logic [3:0] A2, B2, S2;
    logic       Ci2, Co2, busy2, done2, pass2;
    logic [9:0] err2;
    logic [9:0] vec2;
    logic [8:0] ff2;
    assign {Co2, S2} = {1'b0, A2} + {1'b0, B2} + {4'b0, Ci2};

    rca_bist_checker #(.N(4), .SETTLE(0), .ERR_W(10)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2), .Ci(Ci2), .S(S2), .Co(Co2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_count(vec2),
        .first_fail(ff2)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic done_of(input int k);
        case (k)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Monitor: pops one expectation per rising done and compares the reported results
    logic [2:0] done_prev = 3'b000;
    always @(negedge clk) begin
        logic [2:0] done_now;
        done_now = {done2, done1, done0};
        for (int k = 0; k < 3; k++) begin
            if (done_now[k] && !done_prev[k]) begin
                exp_t e;
                int   a_pass, a_err, a_vec, a_ff, a_busy;
                case (k)
                    0: begin a_pass = int'(pass0); a_err = int'(err0); a_vec = int'(vec0);
                             a_ff = int'(ff0); a_busy = int'(busy0); end
                    1: begin a_pass = int'(pass1); a_err = int'(err1); a_vec = int'(vec1);
                             a_ff = int'(ff1); a_busy = int'(busy1); end
                    default: begin a_pass = int'(pass2); a_err = int'(err2); a_vec = int'(vec2);
                             a_ff = int'(ff2); a_busy = int'(busy2); end
                endcase
                if (sb_q.size() == 0) begin
                    check("unexpected_done", k, -1);
                end else begin
                    e = sb_q.pop_front();
                    $display("sweep dut=%0d pass=%0d err=%0d vec=%0d first_fail=%03h cycles=%0d",
                             k, a_pass, a_err, a_vec, a_ff, cyc - e.start_cyc);
                    check("dut_id", k, e.dut);
                    check("pass", a_pass, int'(e.pass));
                    check("err_count", a_err, e.err);
                    check("vec_count", a_vec, e.vec);
                    check("busy_at_done", a_busy, 0);
                    check("latency", cyc - e.start_cyc, e.lat);
                    if (e.chk_ff) check("first_fail", a_ff, e.ff);
                end
            end
        end
        done_prev <= done_now;
    end

    task automatic pulse_start(input int k, input bit push, input exp_t e);
        @(negedge clk);
        case (k)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        if (push) begin
            e.start_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!done_of(k) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done_of(k)) check("timeout_done", k, -1);
        @(negedge clk);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_abci"}, {A0, B0, Ci0}, 0);
        check({tag, "_flags"}, {busy0, done0, pass0}, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_vec"}, vec0, 0);
        check({tag, "_ff"}, ff0, 0);
    endtask

    exp_t e_ok, e_co, e_s0, e_fast;

    initial begin
        e_ok   = '{dut: 0, pass: 1'b1, err: 0,   vec: 512, ff: 0,     chk_ff: 1'b0, lat: 2048, start_cyc: 0};
        e_co   = '{dut: 0, pass: 1'b0, err: 256, vec: 512, ff: 'h01F, chk_ff: 1'b1, lat: 2048, start_cyc: 0};
        e_s0   = '{dut: 1, pass: 1'b0, err: 15,  vec: 512, ff: 'h001, chk_ff: 1'b1, lat: 2048, start_cyc: 0};
        e_fast = '{dut: 2, pass: 1'b1, err: 0,   vec: 512, ff: 0,     chk_ff: 1'b0, lat: 1024, start_cyc: 0};

        repeat (3) @(posedge clk);
        #1;
        check_zero0("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: correct adder
        pulse_start(0, 1'b1, e_ok);
        wait_done(0);
        check("last_vector_held", {A0, B0, Ci0}, 'h1FF);

        // 2: Co stuck-at-0
        co_stuck0 = 1'b1;
        pulse_start(0, 1'b1, e_co);
        wait_done(0);
        co_stuck0 = 1'b0;

        // 3: S[0] stuck-at-0 with 4-bit saturating error counter
        pulse_start(1, 1'b1, e_s0);
        wait_done(1);

        // 4: reset 100 cycles into a sweep, then a clean sweep
        pulse_start(0, 1'b0, e_ok);
        check("restart_clears_done", done0, 0);
        check("restart_busy", busy0, 1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero0("midreset");
        @(negedge clk);
        rst = 1'b0;
        pulse_start(0, 1'b1, e_ok);
        wait_done(0);

        // 5: start while busy is ignored
        pulse_start(0, 1'b1, e_ok);
        repeat (50) @(posedge clk);
        pulse_start(0, 1'b0, e_ok);
        wait_done(0);

        // 6: SETTLE=0, run twice back to back from DONE
        pulse_start(2, 1'b1, e_fast);
        wait_done(2);
        pulse_start(2, 1'b1, e_fast);
        check("rerun_done_cleared", done2, 0);
        check("rerun_vec_cleared", vec2, 0);
        wait_done(2);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
